serial_pattern_gen: RTL and testbench

SERIAL_PATTERN_GEN -- requirements
Module: serial_pattern_gen

---
 rtl/serial_pattern_gen.sv | 146 ++++++++++++++
 tb/tb_serial_pattern_gen.sv | 151 +++++++++++++++
 2 files changed

// File: rtl/serial_pattern_gen.sv
// Serial pattern generator: sends a latched frame MSB-first, repeated reps times, then pulses done.
// Define FRAME_GAP_EN to insert one idle GAP cycle between consecutive frames.
module serial_pattern_gen #(
  parameter int PAT_W = 8,
  parameter int REP_W = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     start,
  input  logic [PAT_W-1:0]         pattern,
  input  logic [$clog2(PAT_W):0]   len,
  input  logic [REP_W-1:0]         reps,
  output logic                     x,
  output logic                     x_valid,
  output logic                     busy,
  output logic                     done
);

  localparam int LEN_W = $clog2(PAT_W) + 1;
  localparam logic [LEN_W-1:0] FULL_LEN = LEN_W'(PAT_W);
  localparam logic [LEN_W-1:0] ONE_LEN  = LEN_W'(1);
  localparam logic [LEN_W-1:0] ZERO_LEN = LEN_W'(0);
  localparam logic [REP_W-1:0] ONE_REP  = REP_W'(1);
  localparam logic [REP_W-1:0] ZERO_REP = REP_W'(0);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SEND = 2'd1,
    GAP  = 2'd2,
    DONE = 2'd3
  } state_t;

  state_t           state_r;
  logic [PAT_W-1:0] pat_r;
  logic [PAT_W-1:0] sh_r;
  logic [LEN_W-1:0] len_r;
  logic [LEN_W-1:0] bit_cnt_r;
  logic [REP_W-1:0] reps_r;
  logic [REP_W-1:0] frame_cnt_r;

  logic [LEN_W-1:0] eff_len_s;
  logic [REP_W-1:0] eff_reps_s;
  logic [PAT_W-1:0] aligned_s;

  // Zero-substitute len/reps and left-align the frame so the shifter always reads the top bit.
  always_comb begin
    eff_len_s  = FULL_LEN;
    eff_reps_s = ONE_REP;
    if ((len != ZERO_LEN) && (len <= FULL_LEN)) begin
      eff_len_s = len;
    end else begin
      eff_len_s = FULL_LEN;
    end
    if (reps != ZERO_REP) begin
      eff_reps_s = reps;
    end else begin
      eff_reps_s = ONE_REP;
    end
    aligned_s = pattern << (FULL_LEN - eff_len_s);
  end

  // Transmission FSM with registered serial outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r     <= IDLE;
      pat_r       <= {PAT_W{1'b0}};
      sh_r        <= {PAT_W{1'b0}};
      len_r       <= ZERO_LEN;
      bit_cnt_r   <= ZERO_LEN;
      reps_r      <= ZERO_REP;
      frame_cnt_r <= ZERO_REP;
      x           <= 1'b0;
      x_valid     <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            pat_r       <= aligned_s;
            sh_r        <= aligned_s << 1'b1;
            len_r       <= eff_len_s;
            reps_r      <= eff_reps_s;
            bit_cnt_r   <= eff_len_s - ONE_LEN;
            frame_cnt_r <= ZERO_REP;
            x           <= aligned_s[PAT_W-1];
            x_valid     <= 1'b1;
            busy        <= 1'b1;
            state_r     <= SEND;
          end else begin
            x       <= 1'b0;
            x_valid <= 1'b0;
            busy    <= 1'b0;
          end
        end
        SEND: begin
          if (bit_cnt_r != ZERO_LEN) begin
            bit_cnt_r <= bit_cnt_r - ONE_LEN;
            x         <= sh_r[PAT_W-1];
            sh_r      <= sh_r << 1'b1;
          end else if (frame_cnt_r == (reps_r - ONE_REP)) begin
            x       <= 1'b0;
            x_valid <= 1'b0;
            done    <= 1'b1;
            state_r <= DONE;
          end else begin
            frame_cnt_r <= frame_cnt_r + ONE_REP;
`ifdef FRAME_GAP_EN
            x       <= 1'b0;
            x_valid <= 1'b0;
            state_r <= GAP;
`else
            // Reload straight away so x_valid stays high across the frame boundary.
            bit_cnt_r <= len_r - ONE_LEN;
            x         <= pat_r[PAT_W-1];
            sh_r      <= pat_r << 1'b1;
`endif
          end
        end
        GAP: begin
          bit_cnt_r <= len_r - ONE_LEN;
          x         <= pat_r[PAT_W-1];
          sh_r      <= pat_r << 1'b1;
          x_valid   <= 1'b1;
          state_r   <= SEND;
        end
        DONE: begin
          done    <= 1'b0;
          busy    <= 1'b0;
          x       <= 1'b0;
          x_valid <= 1'b0;
          state_r <= IDLE;
        end
        default: begin
          x       <= 1'b0;
          x_valid <= 1'b0;
          busy    <= 1'b0;
          done    <= 1'b0;
          state_r <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_serial_pattern_gen.sv
// Scoreboard bench for serial_pattern_gen; expected {x_valid,x,busy,done} per cycle are queued at start.
// Honours FRAME_GAP_EN the same way as the design build.
module tb_serial_pattern_gen;

  logic       clk;
  logic       reset;
  logic       start;
  logic [7:0] pattern;
  logic [3:0] len;
  logic [3:0] reps;
  logic       x;
  logic       x_valid;
  logic       busy;
  logic       done;

  int errors;
  int checks;
  logic [3:0] exp_q[$];

  serial_pattern_gen #(.PAT_W(8), .REP_W(4)) dut (
    .clk     (clk),
    .reset   (reset),
    .start   (start),
    .pattern (pattern),
    .len     (len),
    .reps    (reps),
    .x       (x),
    .x_valid (x_valid),
    .busy    (busy),
    .done    (done)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [3:0] got, input logic [3:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got {vld,x,busy,done}=%b expected %b at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: one entry per cycle, starting with the cycle after the accepting edge.
  task automatic push_model(input logic [7:0] p, input logic [3:0] l, input logic [3:0] r);
    int effl;
    int effr;
    effl = ((l == 4'd0) || (l > 4'd8)) ? 8 : int'(l);
    effr = (r == 4'd0) ? 1 : int'(r);
    for (int f = 0; f < effr; f++) begin
      for (int b = effl - 1; b >= 0; b--) begin
        exp_q.push_back({1'b1, p[b], 1'b1, 1'b0});
      end
`ifdef FRAME_GAP_EN
      if (f < effr - 1) exp_q.push_back(4'b0010);
`endif
    end
    exp_q.push_back(4'b0011);
    exp_q.push_back(4'b0000);
  endtask

  task automatic run_txn(input string tag, input logic [7:0] p, input logic [3:0] l,
                         input logic [3:0] r, input bit noise);
    int n;
    logic [3:0] e;
    push_model(p, l, r);
    start   = 1'b1;
    pattern = p;
    len     = l;
    reps    = r;
    n = exp_q.size();
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
      if (noise) begin
        start   = 1'b1;
        pattern = 8'hFF;
        len     = 4'($urandom_range(0, 8));
        reps    = 4'($urandom_range(0, 15));
      end else begin
        start = 1'b0;
      end
      e = exp_q.pop_front();
      check_eq(tag, {x_valid, x, busy, done}, e);
    end
    start = 1'b0;
  endtask

  task automatic idle_cycles(input string tag, input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
      check_eq(tag, {x_valid, x, busy, done}, 4'b0000);
    end
  endtask

  initial begin
    clk     = 1'b0;
    reset   = 1'b0;
    start   = 1'b0;
    pattern = 8'h00;
    len     = 4'd0;
    reps    = 4'd0;
    errors  = 0;
    checks  = 0;

    #1 reset = 1'b1;
    #1 check_eq("reset", {x_valid, x, busy, done}, 4'b0000);
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    idle_cycles("idle_after_reset", 2);

    run_txn("b_len4_r1",    8'h0B, 4'd4, 4'd1, 1'b0);
    run_txn("b_len4_r2",    8'h0B, 4'd4, 4'd2, 1'b0);
    run_txn("a5_len0_r0",   8'hA5, 4'd0, 4'd0, 1'b0);
    run_txn("restart_ign",  8'h0B, 4'd4, 4'd1, 1'b1);
    run_txn("len1_r3",      8'h01, 4'd1, 4'd3, 1'b0);
    run_txn("len1_zero_r2", 8'h02, 4'd1, 4'd2, 1'b1);
    run_txn("len8_r3",      8'h3C, 4'd8, 4'd3, 1'b0);
    for (int k = 0; k < 6; k++) begin
      run_txn("random", 8'($urandom), 4'($urandom_range(0, 8)), 4'($urandom_range(0, 3)),
              1'($urandom_range(0, 1)));
    end

    // Abort mid-frame with an asynchronous reset between clock edges.
    push_model(8'h0B, 4'd4, 4'd1);
    start   = 1'b1;
    pattern = 8'h0B;
    len     = 4'd4;
    reps    = 4'd1;
    for (int i = 0; i < 2; i++) begin
      @(posedge clk);
      #1;
      start = 1'b0;
      check_eq("pre_abort", {x_valid, x, busy, done}, exp_q.pop_front());
    end
    exp_q.delete();
    #2 reset = 1'b1;
    #1 check_eq("async_abort", {x_valid, x, busy, done}, 4'b0000);
    repeat (2) @(posedge clk);
    #1 check_eq("abort_hold", {x_valid, x, busy, done}, 4'b0000);
    @(negedge clk);
    reset = 1'b0;
    idle_cycles("abort_no_done", 4);
    run_txn("after_abort", 8'h0B, 4'd4, 4'd1, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
